// File: rtl/jalr_target_resolver_pkg.sv
// -----------------------------------------------------------------------------
// jalr_target_resolver_pkg
// Shared definitions for the JALR target resolver slice: datapath width,
// mirrored link-register count, register address width, the handshake FSM
// state type and a small register-address helper.
// -----------------------------------------------------------------------------
package jalr_target_resolver_pkg;

    localparam int XLEN    = 32;
    localparam int REG_NUM = 32;
    localparam int REG_AW  = 5;

    // Output slot state: IDLE means the slot is empty, RESP means a result is
    // being presented on the target port.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    // Register x0 is hardwired to zero; every other address is a real entry.
    function automatic logic is_real_reg(input logic [REG_AW-1:0] addr);
        return (addr != {REG_AW{1'b0}});
    endfunction

endpackage : jalr_target_resolver_pkg

// File: rtl/jalr_target_resolver_link_mirror_rf.sv
// -----------------------------------------------------------------------------
// link_mirror_rf
// Shadow copy of the link registers written by JAL. One write port, one
// combinational read port. Entry 0 is never written and always reads zero.
//
// Ports
//   clk_i     : clock, state updates on the rising edge
//   nrst_i    : asynchronous active-low reset, clears every entry
//   we_i      : write strobe
//   waddr_i   : write address
//   wdata_i   : write data
//   raddr_i   : read address
//   rdata_o   : read data (combinational)
// -----------------------------------------------------------------------------
module link_mirror_rf #(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32,
    parameter int AW      = 5
) (
    input  logic            clk_i,
    input  logic            nrst_i,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] mem_q [REG_NUM];
    logic [XLEN-1:0] mem_d [REG_NUM];
    logic            wr_hit_s;
    logic            rd_hit_s;

    // Writes land only on an existing, non-zero entry.
    assign wr_hit_s = we_i && (waddr_i != {AW{1'b0}}) && (32'(waddr_i) < REG_NUM);
    assign rd_hit_s = (raddr_i != {AW{1'b0}}) && (32'(raddr_i) < REG_NUM);

    // Next-state of the storage array.
    always_comb begin
        for (int i = 0; i < REG_NUM; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_hit_s) begin
            mem_d[waddr_i] = wdata_i;
        end else begin
            mem_d[0] = mem_q[0];
        end
        // Entry 0 is pinned so that a stray value can never be stored there.
        mem_d[0] = {XLEN{1'b0}};
    end

    // Storage flops with asynchronous clear.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            for (int i = 0; i < REG_NUM; i++) begin
                mem_q[i] <= {XLEN{1'b0}};
            end
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Combinational read; x0 and out-of-range addresses read zero.
    always_comb begin
        rdata_o = {XLEN{1'b0}};
        if (rd_hit_s) begin
            rdata_o = mem_q[raddr_i];
        end else begin
            rdata_o = {XLEN{1'b0}};
        end
    end

endmodule : link_mirror_rf

// File: rtl/jalr_target_resolver.sv
// -----------------------------------------------------------------------------
// jalr_target_resolver
// Resolves JALR jump targets early from a mirrored copy of the link registers.
// A request supplies rs1 and the sign-extended offset; one cycle after it is
// accepted the target (base + imm, bit 0 cleared) is presented on a
// valid/ready output port together with a misalignment flag (target bit 1).
// The output slot holds one result and refills in the cycle it drains, so
// back-to-back requests sustain one result per cycle.
//
// Ports
//   clk_i          : clock
//   nrst_i         : asynchronous active-low reset
//   wr_en_i        : link-write strobe (from JAL)
//   wr_addr_i      : link-write destination register
//   wr_data_i      : link-write value (return pc)
//   req_valid_i    : resolve request valid
//   req_ready_o    : resolver can accept a request this cycle
//   rs1_addr_i     : JALR base register
//   imm_i          : sign-extended JALR offset
//   tgt_valid_o    : target result valid
//   tgt_ready_i    : consumer accepts the result
//   tgt_addr_o     : resolved jump target
//   tgt_misalign_o : target not 4-byte aligned
// -----------------------------------------------------------------------------
module jalr_target_resolver #(
    parameter int XLEN    = jalr_target_resolver_pkg::XLEN,
    parameter int REG_NUM = jalr_target_resolver_pkg::REG_NUM
) (
    input  logic                                    clk_i,
    input  logic                                    nrst_i,
    input  logic                                    wr_en_i,
    input  logic [jalr_target_resolver_pkg::REG_AW-1:0] wr_addr_i,
    input  logic [XLEN-1:0]                         wr_data_i,
    input  logic                                    req_valid_i,
    output logic                                    req_ready_o,
    input  logic [jalr_target_resolver_pkg::REG_AW-1:0] rs1_addr_i,
    input  logic [XLEN-1:0]                         imm_i,
    output logic                                    tgt_valid_o,
    input  logic                                    tgt_ready_i,
    output logic [XLEN-1:0]                         tgt_addr_o,
    output logic                                    tgt_misalign_o
);

    import jalr_target_resolver_pkg::*;

    state_e          state_q;
    state_e          state_d;
    logic [XLEN-1:0] tgt_addr_q;
    logic [XLEN-1:0] tgt_addr_d;
    logic            tgt_misalign_q;
    logic            tgt_misalign_d;

    logic [XLEN-1:0] rf_rdata_s;
    logic            accept_s;
    logic            bypass_s;
    logic [XLEN-1:0] base_s;
    logic [XLEN-1:0] sum_s;
    logic [XLEN-1:0] target_s;

    link_mirror_rf #(
        .XLEN    (XLEN),
        .REG_NUM (REG_NUM),
        .AW      (REG_AW)
    ) u_mirror (
        .clk_i   (clk_i),
        .nrst_i  (nrst_i),
        .we_i    (wr_en_i),
        .waddr_i (wr_addr_i),
        .wdata_i (wr_data_i),
        .raddr_i (rs1_addr_i),
        .rdata_o (rf_rdata_s)
    );

    // The slot can take a new request when empty or when it drains this cycle.
    assign req_ready_o = (state_q == IDLE) || tgt_ready_i;
    assign accept_s    = req_valid_i && req_ready_o;

    // A link write to rs1 in the same cycle must be seen by the request,
    // otherwise a JAL immediately followed by its JALR would use a stale base.
    assign bypass_s = wr_en_i && (wr_addr_i == rs1_addr_i) && is_real_reg(rs1_addr_i);

    // Base selection and target arithmetic; the add wraps modulo 2^XLEN.
    always_comb begin
        base_s = rf_rdata_s;
        if (bypass_s) begin
            base_s = wr_data_i;
        end else begin
            base_s = rf_rdata_s;
        end
        sum_s    = base_s + imm_i;
        target_s = {sum_s[XLEN-1:1], 1'b0};
    end

    // Handshake FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (tgt_ready_i && !accept_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result register next value: loaded only on accept, otherwise held so a
    // stalled result is never recomputed from a since-updated mirror.
    always_comb begin
        tgt_addr_d     = tgt_addr_q;
        tgt_misalign_d = tgt_misalign_q;
        if (accept_s) begin
            tgt_addr_d     = target_s;
            tgt_misalign_d = target_s[1];
        end else begin
            tgt_addr_d     = tgt_addr_q;
            tgt_misalign_d = tgt_misalign_q;
        end
    end

    // FSM and result flops; reset drops any pending result.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q        <= IDLE;
            tgt_addr_q     <= {XLEN{1'b0}};
            tgt_misalign_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            tgt_addr_q     <= tgt_addr_d;
            tgt_misalign_q <= tgt_misalign_d;
        end
    end

    assign tgt_valid_o    = (state_q == RESP);
    assign tgt_addr_o     = tgt_addr_q;
    assign tgt_misalign_o = tgt_misalign_q;

endmodule : jalr_target_resolver

// File: tb/tb_jalr_target_resolver.sv
// -----------------------------------------------------------------------------
// tb_jalr_target_resolver
// Directed bench for jalr_target_resolver. A behavioural model (register
// array plus a queue of pending results) is checked against the DUT on every
// falling clock edge; directed literal checks pin the model on the scenarios
// of interest.
// -----------------------------------------------------------------------------
module tb_jalr_target_resolver;

    logic        clk;
    logic        nrst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  rs1_addr;
    logic [31:0] imm;
    logic        tgt_valid;
    logic        tgt_ready;
    logic [31:0] tgt_addr;
    logic        tgt_misalign;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: architectural link registers and results awaiting pickup.
    logic [31:0] m_regs [32];
    logic [31:0] m_pending [$];

    jalr_target_resolver dut (
        .clk_i          (clk),
        .nrst_i         (nrst),
        .wr_en_i        (wr_en),
        .wr_addr_i      (wr_addr),
        .wr_data_i      (wr_data),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .rs1_addr_i     (rs1_addr),
        .imm_i          (imm),
        .tgt_valid_o    (tgt_valid),
        .tgt_ready_i    (tgt_ready),
        .tgt_addr_o     (tgt_addr),
        .tgt_misalign_o (tgt_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model compare and update. The falling edge sits mid-cycle, so the
    // inputs seen here are the ones the DUT will sample at the next rise.
    always @(negedge clk) begin
        logic        m_valid;
        logic        m_ready;
        logic [31:0] base;
        if (!nrst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_pending.delete();
        end
        m_valid = (m_pending.size() != 0);
        m_ready = !m_valid || tgt_ready;
        chk("model_valid", 32'(tgt_valid), 32'(m_valid));
        chk("model_ready", 32'(req_ready), 32'(m_ready));
        if (m_valid) begin
            chk("model_addr", tgt_addr, m_pending[0]);
            chk("model_misalign", 32'(tgt_misalign), 32'(m_pending[0][1]));
        end
        if (!nrst) begin
            chk("model_reset_addr", tgt_addr, 32'h0);
        end else begin
            if (m_valid && tgt_ready) void'(m_pending.pop_front());
            if (req_valid && m_ready) begin
                if (rs1_addr == 5'd0)
                    base = 32'h0;
                else if (wr_en && wr_addr == rs1_addr)
                    base = wr_data;
                else
                    base = m_regs[rs1_addr];
                m_pending.push_back((base + imm) & 32'hFFFF_FFFE);
            end
            if (wr_en && wr_addr != 5'd0) m_regs[wr_addr] = wr_data;
        end
    end

    // Apply one cycle of inputs; returns 1 time unit after the rising edge.
    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic rv, input logic [4:0] ra, input logic [31:0] im,
                        input logic tr);
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        req_valid = rv;
        rs1_addr  = ra;
        imm       = im;
        tgt_ready = tr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        nrst = 1'b0;
        wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
        req_valid = 1'b0; rs1_addr = 5'd0; imm = 32'h0; tgt_ready = 1'b0;

        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        chk("reset_valid", 32'(tgt_valid), 32'h0);
        chk("reset_addr", tgt_addr, 32'h0);
        chk("reset_misalign", 32'(tgt_misalign), 32'h0);
        nrst = 1'b1;
        chk("reset_ready", 32'(req_ready), 32'h1);

        // Plain lookup through the mirror.
        step(1'b1, 5'd1, 32'h0000_0104, 1'b0, 5'd0, 32'h0, 1'b1);
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'h0000_0008, 1'b1);
        chk("x1_valid", 32'(tgt_valid), 32'h1);
        chk("x1_addr", tgt_addr, 32'h0000_010C);
        chk("x1_misalign", 32'(tgt_misalign), 32'h0);

        // Same-cycle bypass, negative offset, bit 0 cleared; back-to-back.
        step(1'b1, 5'd5, 32'h0000_2000, 1'b1, 5'd5, 32'hFFFF_FFFD, 1'b1);
        chk("bypass_addr", tgt_addr, 32'h0000_1FFC);
        chk("bypass_misalign", 32'(tgt_misalign), 32'h0);

        // x0 writes are discarded.
        step(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 32'h0, 1'b1);
        chk("drain_valid", 32'(tgt_valid), 32'h0);
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0000_0006, 1'b1);
        chk("x0_addr", tgt_addr, 32'h0000_0006);
        chk("x0_misalign", 32'(tgt_misalign), 32'h1);
        step(1'b1, 5'd0, 32'h0000_5555, 1'b1, 5'd0, 32'h0000_0008, 1'b1);
        chk("x0_nobypass", tgt_addr, 32'h0000_0008);

        // Wrap-around target, then a 3-cycle hold with a mirror write inside.
        step(1'b1, 5'd2, 32'hFFFF_FFF0, 1'b0, 5'd0, 32'h0, 1'b1);
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h0000_0020, 1'b0);
        chk("hold_valid", 32'(tgt_valid), 32'h1);
        chk("hold_addr0", tgt_addr, 32'h0000_0010);
        for (int k = 0; k < 3; k++) begin
            step((k == 1), 5'd3, 32'hABCD_0000, 1'b1, 5'd1, 32'h0000_0004, 1'b0);
            chk("hold_addr", tgt_addr, 32'h0000_0010);
            chk("hold_ready", 32'(req_ready), 32'h0);
            chk("hold_misalign", 32'(tgt_misalign), 32'h0);
        end
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h0000_0001, 1'b1);
        chk("b2b_valid", 32'(tgt_valid), 32'h1);
        chk("b2b_addr", tgt_addr, 32'hABCD_0000);

        // Overflow on the add wraps silently.
        step(1'b1, 5'd4, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0, 1'b1);
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h0000_0003, 1'b1);
        chk("wrap_addr", tgt_addr, 32'h0000_0002);
        chk("wrap_misalign", 32'(tgt_misalign), 32'h1);

        // Reset while a result is pending.
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'h0, 1'b0);
        chk("pre_reset_valid", 32'(tgt_valid), 32'h1);
        nrst = 1'b0;
        #1;
        chk("async_reset_valid", 32'(tgt_valid), 32'h0);
        chk("async_reset_addr", tgt_addr, 32'h0);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        nrst = 1'b1;
        chk("post_reset_ready", 32'(req_ready), 32'h1);
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'h0000_0057, 1'b1);
        chk("cleared_addr", tgt_addr, 32'h0000_0056);
        chk("cleared_misalign", 32'(tgt_misalign), 32'h1);

        // Mixed traffic: writes, bypass hits, stalls and idle cycles.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 5'((i % 7) + 1), 32'(i * 32'h0111_0000 + 32'h0000_0303),
                 (i % 3 != 2), 5'((i + 1) % 8), 32'(i * 4 + 1), (i % 4 != 3));
        end
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        chk("final_idle", 32'(tgt_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_jalr_target_resolver

// File: doc/jalr_target_resolver.md
JALR_TARGET_RESOLVER -- requirements
Module: jalr_target_resolver

Interface
REQ-001 Parameter XLEN, 32, data/address width in bits.
REQ-002 Parameter REG_NUM, 32, number of mirrored link registers; register address width = 5.
REQ-003 Port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 Port nrst_i  input  1  asynchronous, active-low reset.
REQ-005 Port wr_en_i  input  1  link-write strobe; the JAL link-write signal drives it.
REQ-006 Port wr_addr_i  input  5  link-write destination register.
REQ-007 Port wr_data_i  input  XLEN  link-write value (return pc).
REQ-008 Port req_valid_i  input  1  JALR resolve request valid.
REQ-009 Port req_ready_o  output  1  resolver can accept a request this cycle.
REQ-010 Port rs1_addr_i  input  5  JALR base register.
REQ-011 Port imm_i  input  XLEN  sign-extended JALR offset.
REQ-012 Port tgt_valid_o  output  1  target result valid.
REQ-013 Port tgt_ready_i  input  1  consumer accepts the result.
REQ-014 Port tgt_addr_o  output  XLEN  resolved jump target.
REQ-015 Port tgt_misalign_o  output  1  target not 4-byte aligned (tgt_addr_o[1]==1).

Function
REQ-016 Mirror: on wr_en_i with wr_addr_i!=0, entry[wr_addr_i] SHALL become wr_data_i at the next edge; writes to address 0 are discarded; entry 0 always reads 0.
REQ-017 Handshake: a request is accepted in any cycle where req_valid_i && req_ready_o.
REQ-018 req_ready_o SHALL equal (state==IDLE) || tgt_ready_i (the output slot is empty or draining this cycle).
REQ-019 FSM states: IDLE (tgt_valid_o=0) and RESP (tgt_valid_o=1).
REQ-020 IDLE->RESP on accept; RESP->IDLE on tgt_ready_i without accept; RESP->RESP on tgt_ready_i with accept (back-to-back) or on !tgt_ready_i (hold).
REQ-021 Latency: the result SHALL appear on tgt_addr_o exactly one cycle after acceptance; sustained throughput is one result per cycle.
REQ-022 Target = (base + imm_i) mod 2^XLEN, then bit 0 cleared; overflow wraps silently.
REQ-023 base = wr_data_i when wr_en_i && wr_addr_i==rs1_addr_i && rs1_addr_i!=0 in the accept cycle (same-cycle bypass); otherwise base = entry[rs1_addr_i].
REQ-024 tgt_misalign_o SHALL be registered together with tgt_addr_o and equal the registered target bit 1.
REQ-025 While in RESP with !tgt_ready_i, tgt_addr_o and tgt_misalign_o SHALL hold stable, and req_ready_o SHALL be 0.
REQ-026 Mirror writes SHALL proceed independently of handshake state, including during hold; a held result is not recomputed.

Reset
REQ-027 When nrst_i=0, asynchronously: FSM SHALL enter IDLE; tgt_valid_o=0, tgt_addr_o=0, tgt_misalign_o=0; all mirror entries SHALL be 0.
REQ-028 A result pending at reset assertion SHALL be dropped; after release, req_ready_o=1 in the first cycle.

Structure
REQ-029 Shared package SHALL hold XLEN, REG_NUM, REG_AW=5 and the FSM state enum {IDLE, RESP}.
REQ-030 Mirror storage SHALL be one sub-module, link_mirror_rf: one write port, one combinational read port, asynchronous reset, and the x0 rule; the resolver instantiates it.

Verification
REQ-031 Write x1=0x0000_0104, then request rs1=1, imm=0x8 with tgt_ready_i=1 -> one cycle later tgt_valid_o=1, tgt_addr_o=0x0000_010C, misalign=0.
REQ-032 In the same cycle, write x5=0x0000_2000 and request rs1=5, imm=0xFFFF_FFFD -> tgt_addr_o=0x0000_1FFC (bypass, bit 0 cleared), misalign=0.
REQ-033 Write x0=0x1234, then request rs1=0, imm=0x0000_0006 -> tgt_addr_o=0x0000_0006, misalign=1.
REQ-034 With x2=0xFFFF_FFF0, request rs1=2, imm=0x20 with tgt_ready_i=0 for 3 cycles -> tgt_addr_o=0x0000_0010 held stable and req_ready_o=0 for those cycles; on tgt_ready_i=1, a new request is accepted back-to-back.
REQ-035 Assert nrst_i=0 while in RESP -> tgt_valid_o=0 immediately; a subsequent request on rs1=1 returns imm&~1 (mirror cleared).
